// File: rtl/shared_reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// shared_reg_arb_pkg
// Shared types and constants for the shared-register arbiter slice.
//   - arb_state_e : sequencer states (IDLE, WRITE, HOLD)
//   - PTR_W       : round-robin pointer width for the default NUM_REQ
//   - ptr_width() : pointer width for any NUM_REQ
// No ports (package).
// ---------------------------------------------------------------------------
package shared_reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int PTR_W           = $clog2(DEFAULT_NUM_REQ);

    // Pointer width for a given requester count; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter_if
// Bundles the requester-side bus of the shared-register arbiter.
//   req   : per-requester write request (level)
//   lock  : per-requester ownership hold request
//   wdata : packed write data, slice i belongs to requester i
//   grant : one-hot current owner
//   ack   : one-hot, one-cycle write acknowledge
//   q     : shared register contents
//   busy  : arbiter not idle
// Modports: master (requesters drive req/lock/wdata), slave (arbiter).
// ---------------------------------------------------------------------------
interface shared_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         q;
    logic                      busy;

    modport master (
        output req,
        output lock,
        output wdata,
        input  grant,
        input  ack,
        input  q,
        input  busy
    );

    modport slave (
        input  req,
        input  lock,
        input  wdata,
        output grant,
        output ack,
        output q,
        output busy
    );

endinterface

// File: rtl/shared_reg_rr_pick.sv
// ---------------------------------------------------------------------------
// shared_reg_rr_pick
// Combinational round-robin picker: returns the first set bit of eff_req
// found searching upward from ptr, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   eff_req [NUM_REQ] : candidate requests
//   ptr     [PTR_W]   : search start index
//   winner  [PTR_W]   : index of the chosen requester (valid when valid=1)
//   valid             : at least one candidate present
// ---------------------------------------------------------------------------
module shared_reg_rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int PTR_W_L  = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eff_req,
    input  logic [PTR_W_L-1:0] ptr,
    output logic [PTR_W_L-1:0] winner,
    output logic               valid
);

    int unsigned idx;

    // Walk offsets from the far end down to zero so the smallest offset from
    // ptr that has a request is the last assignment and therefore wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (eff_req[idx]) begin
                valid  = 1'b1;
                winner = idx[PTR_W_L-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin sequencer that lets NUM_REQ requesters share one DATA_W-bit
// register. One owner is chosen per IDLE decision, its data is written in
// the following WRITE cycle and a one-cycle ack marks when q shows it.
// Optional feature macro: SHARED_REG_LOCK_EN (enables HOLD / lock ownership).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : shared_reg_arbiter_if.slave (req, lock, wdata in; grant, ack,
//           q, busy out), all outputs registered
// ---------------------------------------------------------------------------
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int                 NUM_REQ   = 4,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    shared_reg_arbiter_if.slave   bus
);

    localparam int PW = ptr_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] eff_req;
    logic [PW-1:0]      pick_idx;
    logic               pick_valid;

    // A requester whose ack is showing this cycle has not yet had a chance
    // to drop req; masking it prevents a second write of the same data.
    assign eff_req = bus.req & ~ack_q;

    shared_reg_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W_L (PW)
    ) u_pick (
        .eff_req (eff_req),
        .ptr     (ptr_q),
        .winner  (pick_idx),
        .valid   (pick_valid)
    );

    // Next-state logic. grant is held from the decision through WRITE (and
    // HOLD) and cleared whenever the sequencer heads back to IDLE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ack_d   = '0;
        q_d     = q_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = WRITE;
                end
            end

            WRITE: begin
                q_d            = bus.wdata[owner_q*DATA_W +: DATA_W];
                ack_d[owner_q] = 1'b1;
                // The owner just served drops to lowest priority next time.
                if (owner_q == PW'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = owner_q + PW'(1);
                end
`ifdef SHARED_REG_LOCK_EN
                if (bus.lock[owner_q]) begin
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
`else
                state_d = IDLE;
                grant_d = '0;
`endif
            end

            HOLD: begin
`ifdef SHARED_REG_LOCK_EN
                // Others wait here; eff_req masks the owner during its ack
                // cycle so a held req is not written twice.
                if (!bus.lock[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (eff_req[owner_q]) begin
                    state_d = WRITE;
                end
`else
                state_d = IDLE;
                grant_d = '0;
`endif
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state, including the visible outputs, lives in these registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            q_q     <= RESET_VAL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign bus.q     = q_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_reg_arbiter
// Directed bench for shared_reg_arbiter with NUM_REQ=4, DATA_W=8,
// RESET_VAL=8'h00. Follows SHARED_REG_LOCK_EN the same way the RTL does.
// ---------------------------------------------------------------------------
module tb_shared_reg_arbiter;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [7:0] wd [4];
    logic [7:0] lastQ;
    int         expOwn [5];

    shared_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus_if ();

    shared_reg_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the request and lock vectors together.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
        bus_if.req  = r;
        bus_if.lock = l;
    endtask

    // Update one requester's data slice and the bench's copy of it.
    task automatic setData(input int idx, input logic [7:0] v);
        wd[idx]                   = v;
        bus_if.wdata[idx*8 +: 8]  = v;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every visible output against hand-computed values.
    task automatic checkOutput(input string tag, input logic [3:0] eGrant,
                               input logic [3:0] eAck, input logic [7:0] eQ,
                               input logic eBusy);
        checks++;
        assert (bus_if.grant === eGrant) else begin
            errors++;
            $error("[TB] FAIL %s grant: observed %b expected %b", tag, bus_if.grant, eGrant);
        end
        checks++;
        assert (bus_if.ack === eAck) else begin
            errors++;
            $error("[TB] FAIL %s ack: observed %b expected %b", tag, bus_if.ack, eAck);
        end
        checks++;
        assert (bus_if.q === eQ) else begin
            errors++;
            $error("[TB] FAIL %s q: observed %h expected %h", tag, bus_if.q, eQ);
        end
        checks++;
        assert (bus_if.busy === eBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, bus_if.busy, eBusy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expOwn = '{0, 1, 2, 3, 0};

        // Reset held for three cycles with everybody requesting.
        reset = 1'b1;
        applyStimulus(4'b1111, 4'b0000);
        for (int i = 0; i < 4; i++) setData(i, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_hold", 4'b0000, 4'b0000, 8'h00, 1'b0);
        end
        applyStimulus(4'b0000, 4'b0000);
        reset = 1'b0;
        tick();
        checkOutput("idle_after_reset", 4'b0000, 4'b0000, 8'h00, 1'b0);

        // Single request from requester 2.
        $display("[TB] single write by requester 2");
        setData(2, 8'hA5);
        applyStimulus(4'b0100, 4'b0000);
        tick();
        checkOutput("single_grant", 4'b0100, 4'b0000, 8'h00, 1'b1);
        tick();
        checkOutput("single_ack", 4'b0000, 4'b0100, 8'hA5, 1'b0);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("single_after", 4'b0000, 4'b0000, 8'hA5, 1'b0);

        // Requester 2 just served: 3 must win over 0.
        $display("[TB] priority after requester 2");
        setData(3, 8'h33);
        setData(0, 8'hC3);
        applyStimulus(4'b1001, 4'b0000);
        tick();
        checkOutput("rr_grant3", 4'b1000, 4'b0000, 8'hA5, 1'b1);
        tick();
        checkOutput("rr_ack3", 4'b0000, 4'b1000, 8'h33, 1'b0);
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("rr_grant0", 4'b0001, 4'b0000, 8'h33, 1'b1);
        tick();
        checkOutput("rr_ack0", 4'b0000, 4'b0001, 8'hC3, 1'b0);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("rr_idle", 4'b0000, 4'b0000, 8'hC3, 1'b0);

        // Reset during WRITE for requester 3.
        $display("[TB] reset during write");
        setData(3, 8'h5A);
        applyStimulus(4'b1000, 4'b0000);
        tick();
        checkOutput("rst_wr_grant", 4'b1000, 4'b0000, 8'hC3, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_wr_async", 4'b0000, 4'b0000, 8'h00, 1'b0);
        tick();
        checkOutput("rst_wr_held", 4'b0000, 4'b0000, 8'h00, 1'b0);
        reset = 1'b0;
        tick();
        checkOutput("rst_wr_regrant", 4'b1000, 4'b0000, 8'h00, 1'b1);
        tick();
        checkOutput("rst_wr_ack", 4'b0000, 4'b1000, 8'h5A, 1'b0);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("rst_wr_idle", 4'b0000, 4'b0000, 8'h5A, 1'b0);

        // All four requesting continuously, pointer back at 0.
        $display("[TB] continuous requests from all");
        setData(0, 8'h10);
        setData(1, 8'h21);
        setData(2, 8'h32);
        setData(3, 8'h43);
        lastQ = 8'h5A;
        applyStimulus(4'b1111, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("all_grant", 4'(1) << expOwn[k], 4'b0000, lastQ, 1'b1);
            tick();
            checkOutput("all_ack", 4'b0000, 4'(1) << expOwn[k], wd[expOwn[k]], 1'b0);
            lastQ = wd[expOwn[k]];
            setData(expOwn[k], wd[expOwn[k]] ^ 8'hFF);
        end
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("all_idle", 4'b0000, 4'b0000, lastQ, 1'b0);

        // Requester 1 writes twice with lock while requester 0 waits.
        $display("[TB] lock scenario");
        setData(1, 8'h11);
        applyStimulus(4'b0010, 4'b0010);
        tick();
        checkOutput("lock_grant1", 4'b0010, 4'b0000, lastQ, 1'b1);
        setData(0, 8'h99);
        applyStimulus(4'b0011, 4'b0010);
        tick();
`ifdef SHARED_REG_LOCK_EN
        checkOutput("lock_ack11", 4'b0010, 4'b0010, 8'h11, 1'b1);
        setData(1, 8'h22);
        tick();
        checkOutput("lock_hold", 4'b0010, 4'b0000, 8'h11, 1'b1);
        tick();
        checkOutput("lock_write22", 4'b0010, 4'b0000, 8'h11, 1'b1);
        tick();
        checkOutput("lock_ack22", 4'b0010, 4'b0010, 8'h22, 1'b1);
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("lock_release", 4'b0000, 4'b0000, 8'h22, 1'b0);
        tick();
        checkOutput("lock_grant0", 4'b0001, 4'b0000, 8'h22, 1'b1);
        tick();
        checkOutput("lock_ack0", 4'b0000, 4'b0001, 8'h99, 1'b0);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("lock_idle", 4'b0000, 4'b0000, 8'h99, 1'b0);
`else
        checkOutput("nolock_ack11", 4'b0000, 4'b0010, 8'h11, 1'b0);
        setData(1, 8'h22);
        tick();
        checkOutput("nolock_grant0", 4'b0001, 4'b0000, 8'h11, 1'b1);
        tick();
        checkOutput("nolock_ack0", 4'b0000, 4'b0001, 8'h99, 1'b0);
        applyStimulus(4'b0010, 4'b0010);
        tick();
        checkOutput("nolock_grant1", 4'b0010, 4'b0000, 8'h99, 1'b1);
        tick();
        checkOutput("nolock_ack22", 4'b0000, 4'b0010, 8'h22, 1'b0);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("nolock_idle", 4'b0000, 4'b0000, 8'h22, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

- Round-robin arbiter that shares one DATA_W-bit flip-flop register among NUM_REQ requesters.
- Each requester presents a write request with data. The arbiter selects one owner, loads its data into the shared register and returns a one-cycle acknowledge.
- Sits in front of the team's D flip-flop storage as the sequencer deciding who writes it and when.
- Optional lock lets an owner perform back-to-back writes without losing ownership.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, shared register width
- RESET_VAL, '0, value of q during and after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  NUM_REQ  per-requester write request, level
- lock  in  NUM_REQ  per-requester ownership hold request, sampled only while that requester owns
- wdata  in  NUM_REQ*DATA_W  packed write data; slice i belongs to requester i
- grant  out  NUM_REQ  one-hot current owner, zero when idle
- ack  out  NUM_REQ  one-hot, one-cycle pulse marking the cycle q first shows the owner's data
- q  out  DATA_W  shared register contents
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, WRITE, HOLD.
- Outputs are registered, and all registers are reset by reset. Reset values:
  - q = RESET_VAL
  - grant = 0, ack = 0, busy = 0
  - round-robin pointer ptr = 0
  - state = IDLE
- Effective request: eff_req = req & ~ack. The mask blocks a requester whose ack is currently high, which prevents a double write.
- IDLE:
  - If eff_req is nonzero, pick the first set bit searching upward from ptr with wrap-around.
  - Latch the winner as owner, set grant = onehot(owner), and go to WRITE.
  - If eff_req is zero, stay in IDLE.
- WRITE (exactly one cycle):
  - q <= wdata[owner], ack <= onehot(owner).
  - ptr <= owner+1; when owner = NUM_REQ-1, ptr wraps to 0.
  - Next state is HOLD if lock is enabled and lock[owner] = 1, otherwise IDLE. Going to IDLE clears grant.
- HOLD:
  - If lock[owner] = 0, go to IDLE and clear grant.
  - Else if eff_req[owner] = 1, go to WRITE with the same owner.
  - Otherwise stay in HOLD.
  - Other requesters wait, whatever their req.
- Requester rules:
  - Hold req and wdata stable from assertion until ack is observed.
  - Drop req or change data only after ack.
- q changes only in WRITE.
- ack is never high for more than one consecutive cycle per write.

## Timing
- Latency: req sampled at edge t in IDLE.
  - After edge t: grant and busy visible.
  - After edge t+1: q = new data and ack high for one cycle.
- Throughput: at most one write per 2 cycles.
- Simultaneous requests: exactly one winner per IDLE decision, in round-robin order from ptr.
- A requester just served has lowest priority at the next decision.
- Request dropped before it wins: no write and no ack for that requester. A requester must not drop req after grant and before ack.
- Reset asserted mid-operation, including in WRITE: immediate return to reset values. q = RESET_VAL, no ack issued.

## Configuration
- Macro: SHARED_REG_LOCK_EN.
- Defined: the HOLD state and lock behaviour are as described above.
- Undefined:
  - The lock port still exists but is ignored.
  - HOLD is unreachable; WRITE always returns to IDLE.
  - An owner re-requesting competes round-robin like everyone else.

## Structure
- Package shared_reg_arb_pkg:
  - state enum typedef (IDLE, WRITE, HOLD)
  - localparam for the pointer width, $clog2(NUM_REQ)
- Sub-module shared_reg_rr_pick:
  - Purely combinational round-robin picker.
  - Inputs: eff_req, ptr. Outputs: winner index, valid.
  - Instantiated once.

## Test plan
Defaults NUM_REQ=4, DATA_W=8, RESET_VAL=8'h00.
- Reset held 3 cycles with req=4'b1111 -> q=8'h00, grant=0, ack=0, busy=0 throughout.
- req=4'b0100 with wdata[2]=8'hA5 at edge t:
  - grant=4'b0100 after t;
  - q=8'hA5 and ack=4'b0100 after t+1 for one cycle only;
  - requester drops req, then busy=0.
- req=4'b1111 held continuously (each requester re-raises after ack) -> acks in order 0,1,2,3,0, one every 2 cycles; q tracks the matching wdata.
- After serving requester 2, req=4'b1001 -> requester 3 wins before requester 0.
- SHARED_REG_LOCK_EN defined; requester 1 with lock[1]=1 writes 8'h11 then 8'h22 while req[0]=1:
  - both writes by requester 1 complete before requester 0 is acked;
  - requester 0 is granted in the cycle after lock[1] drops.
  - With the macro undefined, requester 0 is acked between 8'h11 and 8'h22.
- Reset asserted during WRITE for requester 3 with wdata=8'h5A -> q=8'h00, no ack; after release with req[3] still high, requester 3 is granted and acked with 8'h5A.
